// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push-buttons and the conditioned button/direction outputs.
// The slave side is the conditioner; the master side drives the raw buttons and consumes the results.
interface button_conditioner_if;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       dir_valid;
  logic [1:0] dir_code;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  dir_valid,
    input  dir_code
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output dir_valid,
    output dir_code
  );
endinterface

// File: rtl/button_conditioner.sv
// Button front end: synchronise, debounce, one-cycle press pulses and a prioritised direction command.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat press pulses (REPEAT_DELAY, then every REPEAT_PERIOD).
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave btn_if
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][3:0] sync_r;
  logic [3:0]                  sync_s;
  logic [3:0]                  stable_r;
  logic [3:0]                  stable_nxt_s;
  logic [3:0][CNT_W-1:0]       db_cnt_r;
  logic [3:0][CNT_W-1:0]       db_cnt_nxt_s;
  logic [3:0]                  rise_s;
  logic [3:0]                  press_nxt_s;
  logic [3:0]                  press_r;
  logic                        dir_valid_r;
  logic                        dir_valid_nxt_s;
  logic [1:0]                  dir_code_r;
  logic [1:0]                  dir_code_nxt_s;

  // Lowest set index wins: UP > RIGHT > DOWN > LEFT.
  function automatic logic [1:0] prio_code(input logic [3:0] v);
    logic [1:0] code;
    casez (v)
      4'b???1: code = 2'd0;
      4'b??10: code = 2'd1;
      4'b?100: code = 2'd2;
      4'b1000: code = 2'd3;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

  // Synchroniser chain; only the last stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_if.btn_raw};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    stable_nxt_s = stable_r;
    db_cnt_nxt_s = db_cnt_r;
    for (int i = 0; i < 4; i++) begin
      if (sync_s[i] == stable_r[i]) begin
        db_cnt_nxt_s[i] = '0;
      end else if (db_cnt_r[i] == CNT_MAX) begin
        stable_nxt_s[i] = sync_s[i];
        db_cnt_nxt_s[i] = '0;
      end else begin
        db_cnt_nxt_s[i] = db_cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 4'b0000;
      db_cnt_r <= '0;
    end else begin
      stable_r <= stable_nxt_s;
      db_cnt_r <= db_cnt_nxt_s;
    end
  end

  assign rise_s = stable_nxt_s & ~stable_r;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [3:0][RPT_W-1:0] rpt_cnt_r;
  logic [3:0][RPT_W-1:0] rpt_cnt_nxt_s;
  logic [3:0]            rpt_armed_r;
  logic [3:0]            rpt_armed_nxt_s;
  logic [3:0]            rpt_fire_s;

  // Counter holds cycles since the last pulse; armed selects period over initial delay.
  always_comb begin
    rpt_cnt_nxt_s   = rpt_cnt_r;
    rpt_armed_nxt_s = rpt_armed_r;
    rpt_fire_s      = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (stable_r[i] && stable_nxt_s[i]) begin
        if (rpt_cnt_r[i] == (rpt_armed_r[i] ? PER_LAST : DLY_LAST)) begin
          rpt_fire_s[i]      = 1'b1;
          rpt_cnt_nxt_s[i]   = '0;
          rpt_armed_nxt_s[i] = 1'b1;
        end else begin
          rpt_cnt_nxt_s[i]   = rpt_cnt_r[i] + RPT_W'(1);
          rpt_armed_nxt_s[i] = rpt_armed_r[i];
        end
      end else begin
        rpt_cnt_nxt_s[i]   = '0;
        rpt_armed_nxt_s[i] = 1'b0;
      end
    end
  end

  // Auto-repeat state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_r   <= '0;
      rpt_armed_r <= 4'b0000;
    end else begin
      rpt_cnt_r   <= rpt_cnt_nxt_s;
      rpt_armed_r <= rpt_armed_nxt_s;
    end
  end

  assign press_nxt_s = rise_s | rpt_fire_s;
`else
  assign press_nxt_s = rise_s;
`endif

  // Direction command follows any press pulse by one cycle; code holds otherwise.
  always_comb begin
    dir_valid_nxt_s = 1'b0;
    dir_code_nxt_s  = dir_code_r;
    if (press_r != 4'b0000) begin
      dir_valid_nxt_s = 1'b1;
      dir_code_nxt_s  = prio_code(press_r);
    end else begin
      dir_valid_nxt_s = 1'b0;
      dir_code_nxt_s  = dir_code_r;
    end
  end

  // Output registers for press pulses and the direction command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_r     <= 4'b0000;
      dir_valid_r <= 1'b0;
      dir_code_r  <= 2'd0;
    end else begin
      press_r     <= press_nxt_s;
      dir_valid_r <= dir_valid_nxt_s;
      dir_code_r  <= dir_code_nxt_s;
    end
  end

  assign btn_if.btn_level = stable_r;
  assign btn_if.btn_press = press_r;
  assign btn_if.dir_valid = dir_valid_r;
  assign btn_if.dir_code  = dir_code_r;

endmodule
